// File: rtl/axi_ar_error_responder_if.sv
// Decoder-side and R-channel signal bundle for the AR error responder.
// AXI_AR_ERR_STATS_EN adds the err_count_o statistics output.
interface axi_ar_error_responder_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6
);
  logic                  sample_ardata_info_i;
  logic [ID_WIDTH-1:0]   arid_i;
  logic [7:0]            arlen_i;
  logic [USER_WIDTH-1:0] aruser_i;
  logic                  error_req_i;
  logic                  outstanding_trans_i;
  logic                  error_gnt_o;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [ID_WIDTH-1:0]   rid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;
  logic [USER_WIDTH-1:0] ruser_o;
  logic                  busy_o;
`ifdef AXI_AR_ERR_STATS_EN
  logic [15:0]           err_count_o;
`endif

  modport slave (
    input  sample_ardata_info_i, arid_i, arlen_i, aruser_i, error_req_i,
           outstanding_trans_i, rready_i,
    output error_gnt_o, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o, ruser_o,
           busy_o
`ifdef AXI_AR_ERR_STATS_EN
    , output err_count_o
`endif
  );

  modport master (
    output sample_ardata_info_i, arid_i, arlen_i, aruser_i, error_req_i,
           outstanding_trans_i, rready_i,
    input  error_gnt_o, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o, ruser_o,
           busy_o
`ifdef AXI_AR_ERR_STATS_EN
    , input err_count_o
`endif
  );
endinterface

// File: rtl/axi_ar_error_responder.sv
// Read-side DECERR slave: captures a failing AR, waits for reads to drain,
// returns an arlen+1 beat error burst, then grants the decoder.
// Optional AXI_AR_ERR_STATS_EN adds a saturating error-burst counter.
module axi_ar_error_responder #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6,
  parameter logic [31:0] ERR_WORD   = 32'hBADC_AB1E,
  parameter logic [1:0]  RESP_CODE  = 2'b11
) (
  input logic                   clk,
  input logic                   rst,
  axi_ar_error_responder_if.slave bus
);

  localparam int unsigned LEN_WIDTH = 8;
  localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;
  localparam int unsigned REP       = DATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, DRAIN, RESP, GNT} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [USER_WIDTH-1:0] ruser_q, ruser_d;
  logic                  rvalid_q, rlast_q, gnt_q, busy_q;
  logic                  capture;

  // Next state plus capture of the failing request's fields
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    rid_d      = rid_q;
    ruser_d    = ruser_q;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sample_ardata_info_i) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.outstanding_trans_i) begin
          state_d    = RESP;
          beat_cnt_d = '0;
        end
      end
      RESP: begin
        if (rvalid_q && bus.rready_i) begin
          if (beat_cnt_q == {1'b0, len_q}) state_d = GNT;
          else                             beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
      end
      GNT: begin
        // A back-to-back error request is accepted without passing through IDLE
        if (bus.sample_ardata_info_i) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      len_d   = bus.arlen_i;
      rid_d   = bus.arid_i;
      ruser_d = bus.aruser_i;
    end
  end

  // Outputs are registered from the next-state so they track the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      rid_q      <= '0;
      ruser_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      gnt_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      rid_q      <= rid_d;
      ruser_q    <= ruser_d;
      rvalid_q   <= (state_d == RESP);
      rlast_q    <= (state_d == RESP) && (beat_cnt_d == {1'b0, len_d});
      gnt_q      <= (state_d == GNT);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.rvalid_o    = rvalid_q;
  assign bus.rlast_o     = rlast_q;
  assign bus.error_gnt_o = gnt_q;
  assign bus.busy_o      = busy_q;
  assign bus.rid_o       = rid_q;
  assign bus.ruser_o     = ruser_q;
  assign bus.rdata_o     = {REP{ERR_WORD}};
  assign bus.rresp_o     = RESP_CODE;

`ifdef AXI_AR_ERR_STATS_EN
  logic [15:0] err_count_q;

  // Completed error bursts, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (state_q == GNT && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end else begin
      err_count_q <= err_count_q;
    end
  end

  assign bus.err_count_o = err_count_q;
`endif

  a_no_sample_while_busy: assert property (@(posedge clk) disable iff (rst)
    (state_q == DRAIN || state_q == RESP) |-> !bus.sample_ardata_info_i);

  a_no_outstanding_in_resp: assert property (@(posedge clk) disable iff (rst)
    (state_q == RESP) |-> !bus.outstanding_trans_i);

  a_sample_with_req: assert property (@(posedge clk) disable iff (rst)
    bus.sample_ardata_info_i |-> bus.error_req_i);

endmodule

// File: tb/tb_axi_ar_error_responder.sv
// Directed vector table plus hand sequences for the AR error responder.
module tb_axi_ar_error_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  axi_ar_error_responder_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6)) bus ();

  axi_ar_error_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sample;
    logic [3:0] id;
    logic [7:0] len;
    logic [5:0] user;
    logic       outst;
    logic       rready;
    logic       e_rvalid;
    logic       e_rlast;
    logic       e_gnt;
    logic       e_busy;
    logic [3:0] e_rid;
    logic [5:0] e_ruser;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic r, logic s, logic [3:0] id, logic [7:0] len,
                              logic [5:0] user, logic o, logic rr, logic rv,
                              logic rl, logic g, logic b, logic [3:0] rid,
                              logic [5:0] ru);
    vec_t v;
    v.rst = r; v.sample = s; v.id = id; v.len = len; v.user = user;
    v.outst = o; v.rready = rr; v.e_rvalid = rv; v.e_rlast = rl;
    v.e_gnt = g; v.e_busy = b; v.e_rid = rid; v.e_ruser = ru;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one error request and accept every beat; reports shape of the burst
  task automatic run_burst(input logic [3:0] id, input logic [7:0] len,
                           input logic [5:0] user, output int beats,
                           output int lasts, output int gnts, output bit shape_ok);
    beats = 0; lasts = 0; gnts = 0; shape_ok = 1'b1;
    bus.sample_ardata_info_i = 1'b1;
    bus.error_req_i          = 1'b1;
    bus.arid_i               = id;
    bus.arlen_i              = len;
    bus.aruser_i             = user;
    bus.outstanding_trans_i  = 1'b0;
    bus.rready_i             = 1'b1;
    tick();
    bus.sample_ardata_info_i = 1'b0;
    bus.error_req_i          = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (bus.rvalid_o) begin
        beats++;
        if (bus.rlast_o) lasts++;
        if (bus.rlast_o != (beats == int'(len) + 1)) shape_ok = 1'b0;
        if (bus.rid_o != id || bus.ruser_o != user) shape_ok = 1'b0;
      end
      if (bus.error_gnt_o) gnts++;
      if (!bus.busy_o) break;
      tick();
    end
  endtask

  int beats, lasts, gnts;
  bit shape_ok;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.sample_ardata_info_i = 1'b0;
    bus.arid_i = '0;
    bus.arlen_i = '0;
    bus.aruser_i = '0;
    bus.error_req_i = 1'b0;
    bus.outstanding_trans_i = 1'b0;
    bus.rready_i = 1'b0;

    //               rst s  id     len    user   o  rr  rv rl g  b  rid    ruser
    vecs[0]  = mk(1, 0, 4'h0, 8'd0, 6'h00, 0, 0,  0, 0, 0, 0, 4'h0, 6'h00);
    vecs[1]  = mk(0, 1, 4'h5, 8'd0, 6'h2A, 0, 1,  0, 0, 0, 1, 4'h5, 6'h2A);
    vecs[2]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 1, 0, 1, 4'h5, 6'h2A);
    vecs[3]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  0, 0, 1, 1, 4'h5, 6'h2A);
    vecs[4]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  0, 0, 0, 0, 4'h5, 6'h2A);
    vecs[5]  = mk(0, 1, 4'hA, 8'd3, 6'h15, 0, 1,  0, 0, 0, 1, 4'hA, 6'h15);
    vecs[6]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 0, 0, 1, 4'hA, 6'h15);
    vecs[7]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 0, 0, 1, 4'hA, 6'h15);
    vecs[8]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 0,  1, 0, 0, 1, 4'hA, 6'h15);
    vecs[9]  = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 0,  1, 0, 0, 1, 4'hA, 6'h15);
    vecs[10] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 0, 0, 1, 4'hA, 6'h15);
    vecs[11] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 1, 0, 1, 4'hA, 6'h15);
    vecs[12] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 0,  1, 1, 0, 1, 4'hA, 6'h15);
    vecs[13] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  0, 0, 1, 1, 4'hA, 6'h15);
    vecs[14] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 0,  0, 0, 0, 0, 4'hA, 6'h15);
    vecs[15] = mk(0, 1, 4'h3, 8'd0, 6'h01, 0, 0,  0, 0, 0, 1, 4'h3, 6'h01);
    vecs[16] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 0,  1, 1, 0, 1, 4'h3, 6'h01);
    vecs[17] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  0, 0, 1, 1, 4'h3, 6'h01);
    vecs[18] = mk(0, 1, 4'h7, 8'd1, 6'h3F, 0, 0,  0, 0, 0, 1, 4'h7, 6'h3F);
    vecs[19] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 0, 0, 1, 4'h7, 6'h3F);
    vecs[20] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  1, 1, 0, 1, 4'h7, 6'h3F);
    vecs[21] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 1,  0, 0, 1, 1, 4'h7, 6'h3F);
    vecs[22] = mk(0, 0, 4'h0, 8'd0, 6'h00, 0, 0,  0, 0, 0, 0, 4'h7, 6'h3F);

    for (int i = 0; i < NVEC; i++) begin
      rst                      = vecs[i].rst;
      bus.sample_ardata_info_i = vecs[i].sample;
      bus.error_req_i          = vecs[i].sample;
      bus.arid_i               = vecs[i].id;
      bus.arlen_i              = vecs[i].len;
      bus.aruser_i             = vecs[i].user;
      bus.outstanding_trans_i  = vecs[i].outst;
      bus.rready_i             = vecs[i].rready;
      tick();
      check($sformatf("v%0d rvalid", i), 64'(bus.rvalid_o), 64'(vecs[i].e_rvalid));
      check($sformatf("v%0d rlast", i), 64'(bus.rlast_o), 64'(vecs[i].e_rlast));
      check($sformatf("v%0d gnt", i), 64'(bus.error_gnt_o), 64'(vecs[i].e_gnt));
      check($sformatf("v%0d busy", i), 64'(bus.busy_o), 64'(vecs[i].e_busy));
      check($sformatf("v%0d rid", i), 64'(bus.rid_o), 64'(vecs[i].e_rid));
      check($sformatf("v%0d ruser", i), 64'(bus.ruser_o), 64'(vecs[i].e_ruser));
      check($sformatf("v%0d rdata", i), bus.rdata_o, 64'hBADCAB1EBADCAB1E);
      check($sformatf("v%0d rresp", i), 64'(bus.rresp_o), 64'h3);
    end
    bus.sample_ardata_info_i = 1'b0;
    bus.error_req_i          = 1'b0;

    // Drain wait: outstanding reads hold off the burst
    bus.sample_ardata_info_i = 1'b1;
    bus.error_req_i          = 1'b1;
    bus.arid_i               = 4'h6;
    bus.arlen_i              = 8'd2;
    bus.aruser_i             = 6'h09;
    bus.outstanding_trans_i  = 1'b1;
    bus.rready_i             = 1'b1;
    tick();
    bus.sample_ardata_info_i = 1'b0;
    bus.error_req_i          = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("drain%0d rvalid,busy", i), 64'({bus.rvalid_o, bus.busy_o}), 64'h1);
      tick();
    end
    bus.outstanding_trans_i = 1'b0;
    tick();
    check("drain release rvalid", 64'(bus.rvalid_o), 64'h1);
    gnts = 0;
    for (int i = 0; i < 20 && bus.busy_o; i++) begin
      tick();
      if (bus.error_gnt_o) gnts++;
    end
    check("drain gnt count", 64'(gnts), 64'h1);
    check("drain idle", 64'(bus.busy_o), 64'h0);

    // Reset in the middle of an 8-beat burst
    bus.sample_ardata_info_i = 1'b1;
    bus.error_req_i          = 1'b1;
    bus.arid_i               = 4'h2;
    bus.arlen_i              = 8'd7;
    bus.aruser_i             = 6'h05;
    bus.outstanding_trans_i  = 1'b0;
    bus.rready_i             = 1'b1;
    tick();
    bus.sample_ardata_info_i = 1'b0;
    bus.error_req_i          = 1'b0;
    tick();
    tick();
    check("midrst beat2 rvalid,rlast", 64'({bus.rvalid_o, bus.rlast_o}), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst rvalid,busy,gnt", 64'({bus.rvalid_o, bus.busy_o, bus.error_gnt_o}), 64'h0);
    check("midrst rid cleared", 64'(bus.rid_o), 64'h0);
    tick();
    check("midrst after gnt,rvalid", 64'({bus.error_gnt_o, bus.rvalid_o}), 64'h0);
    run_burst(4'hC, 8'd1, 6'h0C, beats, lasts, gnts, shape_ok);
    check("postrst beats", 64'(beats), 64'd2);
    check("postrst lasts", 64'(lasts), 64'd1);
    check("postrst gnts", 64'(gnts), 64'd1);
    check("postrst shape", 64'(shape_ok), 64'd1);

    // Maximum length burst
    run_burst(4'h9, 8'd255, 6'h11, beats, lasts, gnts, shape_ok);
    check("max beats", 64'(beats), 64'd256);
    check("max lasts", 64'(lasts), 64'd1);
    check("max gnts", 64'(gnts), 64'd1);
    check("max shape", 64'(shape_ok), 64'd1);

`ifdef AXI_AR_ERR_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats reset", 64'(bus.err_count_o), 64'd0);
    for (int i = 0; i < 3; i++) run_burst(4'h1, 8'd0, 6'h01, beats, lasts, gnts, shape_ok);
    check("stats three", 64'(bus.err_count_o), 64'd3);
    force dut.err_count_q = 16'hFFFF;
    tick();
    release dut.err_count_q;
    run_burst(4'h1, 8'd1, 6'h01, beats, lasts, gnts, shape_ok);
    check("stats saturate", 64'(bus.err_count_o), 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
